// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - RV32 fetch stage and IF/ID register with load-use stall, redirect and imem wait handling.
// Optional IF_ID_PERF_CNT_EN adds stall_cnt/flush_cnt performance counters.
module if_id_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        ID_EX_memread,
    input  logic [4:0]  ID_EX_wr_reg,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_instr,
    output logic        IF_ID_valid,
`ifdef IF_ID_PERF_CNT_EN
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt,
`endif
    output logic        pc_stall,
    output logic        id_bubble
);

    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        load_use;

    assign rs1 = IF_ID_instr[19:15];
    assign rs2 = IF_ID_instr[24:20];

    // A bubble or flushed entry is never a real consumer, so it cannot stall.
    assign load_use = IF_ID_valid & ID_EX_memread & (ID_EX_wr_reg != 5'd0) &
                      ((ID_EX_wr_reg == rs1) | (ID_EX_wr_reg == rs2));

    assign pc_stall  = load_use & ~branch_taken;
    assign id_bubble = load_use | branch_taken;
    assign imem_req  = ~pc_stall & ~rst;
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            IF_ID_PC    <= 32'd0;
            IF_ID_instr <= NOP_INSTR;
            IF_ID_valid <= 1'b0;
        end else if (branch_taken) begin
            pc          <= {branch_target[31:2], 2'b00};
            IF_ID_PC    <= 32'd0;
            IF_ID_instr <= NOP_INSTR;
            IF_ID_valid <= 1'b0;
        end else if (pc_stall) begin
            pc          <= pc;
            IF_ID_PC    <= IF_ID_PC;
            IF_ID_instr <= IF_ID_instr;
            IF_ID_valid <= IF_ID_valid;
        end else if (!imem_ready) begin
            // Wait state: refetch the same PC and feed decode a bubble.
            pc          <= pc;
            IF_ID_PC    <= 32'd0;
            IF_ID_instr <= NOP_INSTR;
            IF_ID_valid <= 1'b0;
        end else begin
            pc          <= pc + 32'd4;
            IF_ID_PC    <= pc;
            IF_ID_instr <= imem_rdata;
            IF_ID_valid <= 1'b1;
        end
    end

`ifdef IF_ID_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (pc_stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (branch_taken) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - table-driven bench for if_id_stage, with hand-written stall sequence.
module tb_if_id_stage;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        ID_EX_memread;
    logic [4:0]  ID_EX_wr_reg;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_instr;
    logic        IF_ID_valid;
    logic        pc_stall;
    logic        id_bubble;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    if_id_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_req      (imem_req),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .ID_EX_memread (ID_EX_memread),
        .ID_EX_wr_reg  (ID_EX_wr_reg),
        .IF_ID_PC      (IF_ID_PC),
        .IF_ID_instr   (IF_ID_instr),
        .IF_ID_valid   (IF_ID_valid),
`ifdef IF_ID_PERF_CNT_EN
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt),
`endif
        .pc_stall      (pc_stall),
        .id_bubble     (id_bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic [31:0] rdata;
        logic        bt;
        logic [31:0] btgt;
        logic        mr;
        logic [4:0]  wr;
        logic        chk;
        logic        e_stall;
        logic        e_bubble;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_valid;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        int exp_stall_cnt;
        int exp_flush_cnt;
        exp_stall_cnt = 0;
        exp_flush_cnt = 0;
        //         rst rdy rdata          bt btgt           mr wr   chk stl bub req addr           pc             instr          v
        vecs[0]  = '{1, 1, 32'h0,         0, 32'h0,         0, 5'd0, 0, 0, 0, 0, 32'h0,         32'h0,         32'h13,        0};
        vecs[1]  = '{1, 1, 32'h0,         0, 32'h0,         0, 5'd0, 1, 0, 0, 0, 32'h0,         32'h0,         32'h13,        0};
        vecs[2]  = '{0, 1, 32'h00500093,  0, 32'h0,         0, 5'd0, 1, 0, 0, 1, 32'h4,         32'h0,         32'h00500093,  1};
        vecs[3]  = '{0, 1, 32'h002081B3,  0, 32'h0,         0, 5'd0, 1, 0, 0, 1, 32'h8,         32'h4,         32'h002081B3,  1};
        vecs[4]  = '{0, 1, 32'h11111111,  0, 32'h0,         1, 5'd2, 1, 1, 1, 0, 32'h8,         32'h4,         32'h002081B3,  1};
        vecs[5]  = '{0, 1, 32'h00418233,  0, 32'h0,         0, 5'd0, 1, 0, 0, 1, 32'hC,         32'h8,         32'h00418233,  1};
        vecs[6]  = '{0, 0, 32'h33333333,  0, 32'h0,         1, 5'd0, 1, 0, 0, 1, 32'hC,         32'h0,         32'h13,        0};
        vecs[7]  = '{0, 0, 32'h33333333,  0, 32'h0,         0, 5'd0, 1, 0, 0, 1, 32'hC,         32'h0,         32'h13,        0};
        vecs[8]  = '{0, 0, 32'h33333333,  0, 32'h0,         0, 5'd0, 1, 0, 0, 1, 32'hC,         32'h0,         32'h13,        0};
        vecs[9]  = '{0, 1, 32'h002081B3,  0, 32'h0,         0, 5'd0, 1, 0, 0, 1, 32'h10,        32'hC,         32'h002081B3,  1};
        vecs[10] = '{0, 1, 32'h22222222,  1, 32'h00000103,  1, 5'd1, 1, 0, 1, 1, 32'h100,       32'h0,         32'h13,        0};
        vecs[11] = '{0, 0, 32'h22222222,  1, 32'hFFFFFFFF,  0, 5'd0, 1, 0, 1, 1, 32'hFFFFFFFC,  32'h0,         32'h13,        0};
        vecs[12] = '{0, 1, 32'h00100093,  0, 32'h0,         0, 5'd0, 1, 0, 0, 1, 32'h0,         32'hFFFFFFFC,  32'h00100093,  1};
        vecs[13] = '{0, 1, 32'h00200113,  0, 32'h0,         0, 5'd0, 1, 0, 0, 1, 32'h4,         32'h0,         32'h00200113,  1};
        vecs[14] = '{0, 0, 32'h44444444,  0, 32'h0,         0, 5'd0, 1, 0, 0, 1, 32'h4,         32'h0,         32'h13,        0};
        vecs[15] = '{1, 0, 32'h44444444,  1, 32'h00000200,  0, 5'd0, 1, 0, 1, 0, 32'h0,         32'h0,         32'h13,        0};
        vecs[16] = '{0, 1, 32'h00500093,  0, 32'h0,         0, 5'd0, 1, 0, 0, 1, 32'h4,         32'h0,         32'h00500093,  1};

        rst = 1'b1; imem_ready = 1'b0; imem_rdata = '0; branch_taken = 1'b0;
        branch_target = '0; ID_EX_memread = 1'b0; ID_EX_wr_reg = '0;
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            rst           = vecs[i].rst;
            imem_ready    = vecs[i].rdy;
            imem_rdata    = vecs[i].rdata;
            branch_taken  = vecs[i].bt;
            branch_target = vecs[i].btgt;
            ID_EX_memread = vecs[i].mr;
            ID_EX_wr_reg  = vecs[i].wr;
            #1;
            if (vecs[i].chk) begin
                check($sformatf("v%0d pc_stall", i),  {31'd0, pc_stall},  {31'd0, vecs[i].e_stall});
                check($sformatf("v%0d id_bubble", i), {31'd0, id_bubble}, {31'd0, vecs[i].e_bubble});
                check($sformatf("v%0d imem_req", i),  {31'd0, imem_req},  {31'd0, vecs[i].e_req});
            end
            if (vecs[i].rst) begin
                exp_stall_cnt = 0;
                exp_flush_cnt = 0;
            end else begin
                exp_stall_cnt += int'(vecs[i].e_stall);
                exp_flush_cnt += int'(vecs[i].bt);
            end
            @(posedge clk);
            #1;
            check($sformatf("v%0d imem_addr", i),   imem_addr,              vecs[i].e_addr);
            check($sformatf("v%0d IF_ID_PC", i),    IF_ID_PC,               vecs[i].e_pc);
            check($sformatf("v%0d IF_ID_instr", i), IF_ID_instr,            vecs[i].e_instr);
            check($sformatf("v%0d IF_ID_valid", i), {31'd0, IF_ID_valid},   {31'd0, vecs[i].e_valid});
`ifdef IF_ID_PERF_CNT_EN
            check($sformatf("v%0d stall_cnt", i), stall_cnt, exp_stall_cnt);
            check($sformatf("v%0d flush_cnt", i), flush_cnt, exp_flush_cnt);
`endif
            @(negedge clk);
        end

        // Stall on rs2 of addi x1,x0,5 lasts one cycle; rdata changes during it must not leak.
        ID_EX_memread = 1'b1; ID_EX_wr_reg = 5'd5; imem_ready = 1'b1; imem_rdata = 32'hDEADBEEF;
        #1;
        check("seq stall pc_stall", {31'd0, pc_stall}, 32'd1);
        check("seq stall imem_req", {31'd0, imem_req}, 32'd0);
        @(posedge clk); #1;
        check("seq stall hold pc",    imem_addr,   32'h4);
        check("seq stall hold instr", IF_ID_instr, 32'h00500093);
        @(negedge clk);
        ID_EX_memread = 1'b0; imem_rdata = 32'h00A00193;
        #1;
        check("seq release pc_stall", {31'd0, pc_stall}, 32'd0);
        @(posedge clk); #1;
        check("seq release pc",    imem_addr,   32'h8);
        check("seq release IF_ID_PC", IF_ID_PC, 32'h4);
        check("seq release instr", IF_ID_instr, 32'h00A00193);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
